// File: rtl/sram_key_pkg.sv
// Shared types and constants for the SRAM/OTP scrambling-key arbiter.
package sram_key_pkg;

  localparam int unsigned KeyW   = 64;
  localparam int unsigned NonceW = 31;
  localparam int unsigned RspW   = 1 + NonceW + KeyW;

  typedef struct packed {
    logic              seed_valid;
    logic [NonceW-1:0] nonce;
    logic [KeyW-1:0]   key;
  } sram_otp_key_rsp_t;

  localparam sram_otp_key_rsp_t RspZero = '0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

endpackage

// File: rtl/sram_key_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module sram_key_rr_arb #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]         req,
  input  logic [$clog2(NumReq)-1:0] ptr,
  output logic                      valid,
  output logic [$clog2(NumReq)-1:0] idx
);

  localparam int unsigned IdxW = $clog2(NumReq);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand     = (32'(ptr) + i) % NumReq;
      cand_idx = IdxW'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sram_otp_key_arb.sv
// Shares one OTP key port between NumReq SRAM controllers with round-robin
// arbitration, a 4-phase OTP handshake and timeout abort.
module sram_otp_key_arb
  import sram_key_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] ack_o,
  output logic [RspW-1:0]   rsp_o,
  output logic              key_req_o,
  input  logic              key_ack_i,
  input  logic [RspW-1:0]   key_rsp_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(TimeoutCycles);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, winner_q, pick_idx;
  logic            pick_valid;
  logic [CntW-1:0] cnt_q;
  logic            at_limit;

  sram_key_rr_arb #(
    .NumReq(NumReq)
  ) u_rr_arb (
    .req  (req_i),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign at_limit = (cnt_q == CntW'(TimeoutCycles - 1));
  assign busy_o   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = REQ;
      REQ:     if (key_ack_i || at_limit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ack_o/timeout_o are loaded on the REQ->RESP edge so they are registered
  // pulses that coincide with the RESP cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o     <= '0;
      rsp_o     <= '0;
      key_req_o <= 1'b0;
      timeout_o <= 1'b0;
      ptr_q     <= '0;
      winner_q  <= '0;
      cnt_q     <= '0;
    end else begin
      ack_o     <= '0;
      timeout_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            winner_q  <= pick_idx;
            key_req_o <= 1'b1;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (key_ack_i) begin
            rsp_o     <= key_rsp_i;
            key_req_o <= 1'b0;
            ack_o     <= NumReq'(1) << winner_q;
          end else if (at_limit) begin
            rsp_o     <= RspZero;
            key_req_o <= 1'b0;
            ack_o     <= NumReq'(1) << winner_q;
            timeout_o <= 1'b1;
          end
        end
        RESP: begin
          cnt_q <= '0;
          ptr_q <= (winner_q == IdxW'(NumReq - 1)) ? '0 : winner_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_otp_key_arb.sv
// Randomised self-checking bench for sram_otp_key_arb against a transaction-level model.
module tb_sram_otp_key_arb;

  localparam int N  = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_i;
  logic [N-1:0]  ack_o;
  logic [95:0]   rsp_o;
  logic          key_req_o;
  logic          key_ack_i;
  logic [95:0]   key_rsp_i;
  logic          busy_o;
  logic          timeout_o;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] pending;
  int           ptr;

  always #5 clk = ~clk;

  sram_otp_key_arb #(
    .NumReq(N),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .req_i(req_i),
    .ack_o(ack_o),
    .rsp_o(rsp_o),
    .key_req_o(key_req_o),
    .key_ack_i(key_ack_i),
    .key_rsp_i(key_rsp_i),
    .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [95:0] junk();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge while the DUT is in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic do_txn(input logic [N-1:0] raise, input int ack_at,
                        input logic [95:0] data, input bit drop_winner);
    int           w, kr, exp_kr;
    bit           seen, exp_to;
    logic [95:0]  exp_rsp;
    logic [N-1:0] exp_ack;
    pending |= raise;
    if (pending == '0) pending[$urandom_range(N - 1)] = 1'b1;
    req_i   = pending;
    w       = pick(pending, ptr);
    exp_ack = N'(1) << w;
    exp_to  = (ack_at > TO);
    exp_kr  = exp_to ? TO : ack_at;
    exp_rsp = exp_to ? 96'h0 : data;
    kr      = 0;
    seen    = 1'b0;
    for (int c = 0; c < TO + 6 && !seen; c++) begin
      @(negedge clk);
      if (ack_o != '0) begin
        seen = 1'b1;
        check("ack_winner", ack_o, exp_ack);
        check("rsp", rsp_o, exp_rsp);
        check("timeout", timeout_o, exp_to);
        check("key_req_in_ack", key_req_o, 1'b0);
        check("busy_in_ack", busy_o, 1'b1);
        check("key_req_cycles", kr, exp_kr);
        pending[w] = 1'b0;
        req_i      = pending;
        key_ack_i  = 1'b0;
      end else if (key_req_o) begin
        kr++;
        if (kr == 1) check("req_latency", c, 0);
        if (kr == 2) begin
          if (drop_winner) pending[w] = 1'b0;
          pending |= N'($urandom) & ~exp_ack;
          req_i = pending;
        end
        key_ack_i = (kr == ack_at);
        key_rsp_i = (kr == ack_at) ? data : junk();
      end else begin
        key_ack_i = 1'($urandom);
        key_rsp_i = junk();
      end
    end
    if (!seen) check("ack_seen", 1'b0, 1'b1);
    ptr = (w + 1) % N;
    @(negedge clk);
    check("idle_ack", ack_o, '0);
    check("idle_busy", busy_o, 1'b0);
    check("idle_timeout", timeout_o, 1'b0);
    check("rsp_hold", rsp_o, exp_rsp);
    key_ack_i = 1'($urandom);
    key_rsp_i = junk();
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_i     = '0;
    key_ack_i = 1'b0;
    key_rsp_i = '0;
    pending   = '0;
    ptr       = 0;
    #1;
    check("rst_ack", ack_o, '0);
    check("rst_rsp", rsp_o, 96'h0);
    check("rst_key_req", key_req_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_timeout", timeout_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    do_txn(4'b0100, 3, 96'h8_ABCDEF0_0123456789ABCDEF, 1'b0);

    // Asynchronous reset while key_req_o is high.
    pending = 4'b1001;
    req_i   = pending;
    @(negedge clk);
    check("pre_rst_key_req", key_req_o, 1'b1);
    check("pre_rst_busy", busy_o, 1'b1);
    #3 rst_ni = 1'b0;
    #1;
    check("mid_rst_key_req", key_req_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_ack", ack_o, '0);
    check("mid_rst_rsp", rsp_o, 96'h0);
    key_ack_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    ptr    = 0;

    for (int i = 0; i < 5; i++) do_txn(4'b1111, 1, junk(), 1'b0);

    do_txn('0, TO + 1, junk(), 1'b0);
    do_txn('0, TO, junk(), 1'b0);
    do_txn(4'b0110, 4, junk(), 1'b1);
    do_txn(4'b0100, 2, junk(), 1'b0);

    for (int i = 0; i < 150; i++)
      do_txn(N'($urandom), $urandom_range(1, TO + 2), junk(), ($urandom_range(3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_otp_key_arb.md
Name: sram_otp_key_arb

Overview:
- Shares the single OTP scrambling-key interface between NumReq SRAM controllers.
- Each controller raises a level request. The block picks one by round-robin and runs one 4-phase transaction to OTP.
- It captures the 96-bit sram_otp_key_rsp_t response and returns it to the winner with a one-cycle ack.
- Sits between the SRAM controller instances and the OTP controller key port. Provides timeout protection if OTP never answers.

Parameters:
- NumReq, 4, number of SRAM requesters (2..8).
- TimeoutCycles, 1024, cycles key_req_o may stay high without key_ack_i before the transaction is aborted (>=2).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_i  input  NumReq  per-requester level request; held until that requester's ack_o.
- ack_o  output  NumReq  one-hot one-cycle grant-complete pulse.
- rsp_o  output  96  registered response; valid in the ack_o cycle. Layout {seed_valid[95], nonce[94:64], key[63:0]}.
- key_req_o  output  1  request to OTP.
- key_ack_i  input  1  OTP ack; response is valid in the same cycle.
- key_rsp_i  input  96  OTP response, same layout as rsp_o.
- busy_o  output  1  high in any state other than IDLE.
- timeout_o  output  1  one-cycle pulse when a transaction is aborted by timeout.

Behaviour:
- Reset values: ack_o=0, rsp_o=0, key_req_o=0, busy_o=0, timeout_o=0; FSM=IDLE; rr pointer=0; timeout counter=0. Reset is asynchronous and may assert mid-transaction: all state clears immediately and no ack is emitted.
- IDLE:
  - If req_i != 0, pick the first asserted bit at or after the rr pointer, wrapping modulo NumReq.
  - Latch the winner index and go to REQ.
  - key_req_o is registered and goes high in the first REQ cycle.
- REQ:
  - key_req_o=1. The counter increments each cycle.
  - On key_ack_i=1: capture key_rsp_i into rsp_o, clear key_req_o, go to RESP.
  - Else if counter == TimeoutCycles-1: load rsp_o=0 (seed_valid=0), clear key_req_o, set the timeout flag, go to RESP.
  - key_ack_i arriving in the same cycle as the timeout threshold: the ack wins and no timeout is flagged.
- RESP:
  - ack_o[winner]=1 for exactly one cycle. timeout_o=1 in the same cycle if the transaction was aborted.
  - rr pointer <= (winner+1) mod NumReq. Counter cleared. Go to IDLE.
- Latency: req_i sampled high in cycle 0 → key_req_o in cycle 1. key_ack_i in cycle k → ack_o in cycle k+1. Minimum is ack_o in cycle 2.
- The winner is fixed once latched. Its req_i dropping mid-transaction does not abort; the ack is still pulsed.
- Non-winners raising or dropping req_i during a transaction have no effect until the next IDLE.
- Requesters deassert req_i no later than the cycle after ack_o. Back-to-back: IDLE is re-entered for at least one cycle between transactions.
- key_ack_i while not in REQ is ignored.
- rsp_o holds its last value between transactions.
- Fairness: with all NumReq requesting continuously, each is served once per NumReq transactions.

Decomposition:
- Package sram_key_pkg holds:
  - sram_otp_key_rsp_t (seed_valid 1 b, nonce 31 b, key 64 b; 96 b total) and its width constants.
  - the FSM state enum {IDLE, REQ, RESP}.
  - a zero-response constant.
- Sub-module sram_key_rr_arb: combinational round-robin picker. Inputs req vector and pointer; outputs valid and winner index. Parameterised by NumReq.

Test Plan:
- Single request: req_i=4'b0100; OTP acks in the 3rd key_req_o cycle with rsp=96'h8_ABCDEF0_0123456789ABCDEF → ack_o=4'b0100 one cycle after the OTP ack, rsp_o equal to that value, key_req_o low in the ack cycle.
- Round-robin: req_i=4'b1111 held, OTP acks immediately → ack order 0,1,2,3,0. A requester drops its req after its ack and re-raises it two cycles later → it waits its turn.
- Timeout: TimeoutCycles=8, OTP never acks → key_req_o high exactly 8 cycles, then ack_o to the winner with rsp_o=0 and timeout_o=1 in the same cycle.
- Ack at threshold: key_ack_i on the 8th REQ cycle (TimeoutCycles=8) → rsp_o=key_rsp_i, timeout_o=0.
- Reset mid-REQ: assert rst_ni=0 asynchronously while key_req_o=1 → key_req_o, busy_o and ack_o drop immediately; after release, rr pointer=0 and requester 0 wins first.
- Winner drops req mid-transaction: req_i[1] falls while in REQ → transaction completes and ack_o[1] still pulses; the next grant goes to requester 2 if it is requesting.
